// File: rtl/frame_buf_wr_arb_if.sv
// Producer/memory-side bundle of the frame-buffer write arbiter.
// The slave view belongs to the arbiter, the master view to producers and memory.
interface frame_buf_wr_arb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ptr_clr;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          mem_wr_en_n;
    logic [ADDR_WIDTH-1:0]         mem_wr_addr;
    logic [DATA_WIDTH-1:0]         mem_wr_data;
    logic                          mem_wr_rdy;
    logic [NUM_REQ-1:0]            frame_done;

    modport slave (
        input  req,
        input  req_data,
        input  ptr_clr,
        input  mem_wr_rdy,
        output gnt,
        output ack,
        output mem_wr_en_n,
        output mem_wr_addr,
        output mem_wr_data,
        output frame_done
    );

    modport master (
        output req,
        output req_data,
        output ptr_clr,
        output mem_wr_rdy,
        input  gnt,
        input  ack,
        input  mem_wr_en_n,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  frame_done
    );
endinterface

// File: rtl/frame_buf_wr_arb.sv
// Round-robin burst arbiter sharing one frame-buffer write port between NUM_REQ producers,
// each writing into its own wrapping address region.
module frame_buf_wr_arb #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned REGION_DEPTH = (1 << ADDR_WIDTH) / NUM_REQ
) (
    input  logic              wr_clk,
    input  logic              reset,
    frame_buf_wr_arb_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W  = (REGION_DEPTH > 1) ? $clog2(REGION_DEPTH) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]      ptr_q [NUM_REQ];
    logic [PTR_W-1:0]      ptr_d [NUM_REQ];
    logic                  mem_wr_en_n_q, mem_wr_en_n_d;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [NUM_REQ-1:0]    frame_done_q, frame_done_d;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      next_rr;
    logic                  owner_req;
    logic                  beat;
    logic                  last_beat;
    logic                  region_wrap;
    logic [PTR_W-1:0]      owner_ptr;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [ADDR_WIDTH-1:0] owner_addr;

    // Circular scan for the first requester at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Owner-side view: its request, data slice and region pointer.
    always_comb begin
        owner_data = '0;
        owner_ptr  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner_ptr  = ptr_q[i];
            end
        end
    end

    assign owner_req   = bus.req[owner_q];
    assign owner_addr  = ADDR_WIDTH'(32'(owner_q) * REGION_DEPTH + 32'(owner_ptr));
    assign beat        = !reset && (state_q == BURST) && owner_req && bus.mem_wr_rdy;
    assign last_beat   = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    assign region_wrap = (owner_ptr == PTR_W'(REGION_DEPTH - 1));
    assign next_rr     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // gnt_q is one-hot on the owner, so gating it by the beat yields ack.
    assign bus.ack = beat ? gnt_q : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        mem_wr_en_n_d = 1'b1;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        frame_done_d  = '0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (pick_idx == IDX_W'(i));
                    end
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (beat) begin
                    mem_wr_en_n_d = 1'b0;
                    mem_wr_addr_d = owner_addr;
                    mem_wr_data_d = owner_data;
                    beat_cnt_d    = beat_cnt_q + BEAT_W'(1);
                end
                // A stall never ends the burst; only the last beat or a released request does.
                if ((beat && last_beat) || !owner_req) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = next_rr;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        // Region pointers: clear wins over the increment of a coincident beat.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ptr_d[i] = ptr_q[i];
            if (beat && (owner_q == IDX_W'(i))) begin
                ptr_d[i]        = region_wrap ? '0 : ptr_q[i] + PTR_W'(1);
                frame_done_d[i] = region_wrap;
            end
            if (bus.ptr_clr[i]) begin
                ptr_d[i] = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            mem_wr_en_n_q <= 1'b1;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            frame_done_q  <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            mem_wr_en_n_q <= mem_wr_en_n_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            frame_done_q  <= frame_done_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.mem_wr_en_n = mem_wr_en_n_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_frame_buf_wr_arb.sv
// Directed bench for frame_buf_wr_arb: a per-cycle vector table plus a contention sequence.
module tb_frame_buf_wr_arb;
    logic wr_clk;
    logic reset;
    int   checks;
    int   errors;

    frame_buf_wr_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .NUM_REQ(2)) bus ();

    frame_buf_wr_arb #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (3),
        .NUM_REQ     (2),
        .BURST_LEN   (4),
        .REGION_DEPTH(4)
    ) dut (
        .wr_clk(wr_clk),
        .reset (reset),
        .bus   (bus)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  clr;
        logic        rdy;
        logic [1:0]  ack;
        logic [1:0]  gnt;
        logic        en_n;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [1:0]  fd;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic [1:0] req, input logic [31:0] d0,
                     input logic [31:0] d1, input logic [1:0] clr, input logic rdy,
                     input logic [1:0] ack, input logic [1:0] gnt, input logic en_n,
                     input logic [2:0] addr, input logic [31:0] data, input logic [1:0] fd);
        vec_t r;
        r.rst = rst; r.req = req; r.d0 = d0; r.d1 = d1; r.clr = clr; r.rdy = rdy;
        r.ack = ack; r.gnt = gnt; r.en_n = en_n; r.addr = addr; r.data = data; r.fd = fd;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_gnt;
        int         wait_cnt;
        int         beats;

        checks = 0;
        errors = 0;

        // Fields: rst req d0 d1 clr rdy | ack gnt en_n addr data fd
        v(1, 2'b01, 32'hA0, 32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'h0,  2'b00);
        // single requester, four beats into region 0
        v(0, 2'b01, 32'hA0, 32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'h0,  2'b00);
        v(0, 2'b01, 32'hA0, 32'h0,  2'b00, 1, 2'b01, 2'b01, 1, 3'd0, 32'h0,  2'b00);
        v(0, 2'b01, 32'hA1, 32'h0,  2'b00, 1, 2'b01, 2'b01, 0, 3'd0, 32'hA0, 2'b00);
        v(0, 2'b01, 32'hA2, 32'h0,  2'b00, 1, 2'b01, 2'b01, 0, 3'd1, 32'hA1, 2'b00);
        v(0, 2'b01, 32'hA3, 32'h0,  2'b00, 1, 2'b01, 2'b01, 0, 3'd2, 32'hA2, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 0, 3'd3, 32'hA3, 2'b01);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd3, 32'hA3, 2'b00);
        // contention: requester 1 first (rr_ptr=1), region 4..7
        v(0, 2'b11, 32'hB0, 32'hC0, 2'b00, 1, 2'b00, 2'b00, 1, 3'd3, 32'hA3, 2'b00);
        v(0, 2'b11, 32'hB0, 32'hC0, 2'b00, 1, 2'b10, 2'b10, 1, 3'd3, 32'hA3, 2'b00);
        v(0, 2'b11, 32'hB0, 32'hC1, 2'b00, 1, 2'b10, 2'b10, 0, 3'd4, 32'hC0, 2'b00);
        v(0, 2'b11, 32'hB0, 32'hC2, 2'b00, 1, 2'b10, 2'b10, 0, 3'd5, 32'hC1, 2'b00);
        v(0, 2'b11, 32'hB0, 32'hC3, 2'b00, 1, 2'b10, 2'b10, 0, 3'd6, 32'hC2, 2'b00);
        v(0, 2'b11, 32'hB0, 32'hC3, 2'b00, 1, 2'b00, 2'b00, 0, 3'd7, 32'hC3, 2'b10);
        // rr_ptr wrapped to 0; stall of 3 cycles after beat 2
        v(0, 2'b11, 32'hB0, 32'hC3, 2'b00, 1, 2'b01, 2'b01, 1, 3'd7, 32'hC3, 2'b00);
        v(0, 2'b11, 32'hB1, 32'hC3, 2'b00, 1, 2'b01, 2'b01, 0, 3'd0, 32'hB0, 2'b00);
        v(0, 2'b11, 32'hB2, 32'hC3, 2'b00, 0, 2'b00, 2'b01, 0, 3'd1, 32'hB1, 2'b00);
        v(0, 2'b11, 32'hB2, 32'hC3, 2'b00, 0, 2'b00, 2'b01, 1, 3'd1, 32'hB1, 2'b00);
        v(0, 2'b11, 32'hB2, 32'hC3, 2'b00, 0, 2'b00, 2'b01, 1, 3'd1, 32'hB1, 2'b00);
        v(0, 2'b11, 32'hB2, 32'hC3, 2'b00, 1, 2'b01, 2'b01, 1, 3'd1, 32'hB1, 2'b00);
        v(0, 2'b11, 32'hB3, 32'hC3, 2'b00, 1, 2'b01, 2'b01, 0, 3'd2, 32'hB2, 2'b00);
        // early release: requester 1 writes 4,5 then drops req
        v(0, 2'b11, 32'hB3, 32'hD0, 2'b00, 1, 2'b00, 2'b00, 0, 3'd3, 32'hB3, 2'b01);
        v(0, 2'b11, 32'hB3, 32'hD0, 2'b00, 1, 2'b10, 2'b10, 1, 3'd3, 32'hB3, 2'b00);
        v(0, 2'b11, 32'hB3, 32'hD1, 2'b00, 1, 2'b10, 2'b10, 0, 3'd4, 32'hD0, 2'b00);
        v(0, 2'b01, 32'hB3, 32'hD1, 2'b00, 1, 2'b00, 2'b10, 0, 3'd5, 32'hD1, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd5, 32'hD1, 2'b00);
        // resume at 6, wrap after 7
        v(0, 2'b10, 32'h0,  32'hD2, 2'b00, 1, 2'b00, 2'b00, 1, 3'd5, 32'hD1, 2'b00);
        v(0, 2'b10, 32'h0,  32'hD2, 2'b00, 1, 2'b10, 2'b10, 1, 3'd5, 32'hD1, 2'b00);
        v(0, 2'b10, 32'h0,  32'hD3, 2'b00, 1, 2'b10, 2'b10, 0, 3'd6, 32'hD2, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b10, 0, 3'd7, 32'hD3, 2'b10);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd7, 32'hD3, 2'b00);
        // ptr_clr coincident with the beat at address 2
        v(0, 2'b01, 32'hE0, 32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd7, 32'hD3, 2'b00);
        v(0, 2'b01, 32'hE0, 32'h0,  2'b00, 1, 2'b01, 2'b01, 1, 3'd7, 32'hD3, 2'b00);
        v(0, 2'b01, 32'hE1, 32'h0,  2'b00, 1, 2'b01, 2'b01, 0, 3'd0, 32'hE0, 2'b00);
        v(0, 2'b01, 32'hE2, 32'h0,  2'b01, 1, 2'b01, 2'b01, 0, 3'd1, 32'hE1, 2'b00);
        v(0, 2'b01, 32'hE3, 32'h0,  2'b00, 1, 2'b01, 2'b01, 0, 3'd2, 32'hE2, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 0, 3'd0, 32'hE3, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'hE3, 2'b00);
        // reset after beat 1 of a requester 1 burst
        v(0, 2'b10, 32'h0,  32'hF0, 2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'hE3, 2'b00);
        v(0, 2'b10, 32'h0,  32'hF0, 2'b00, 1, 2'b10, 2'b10, 1, 3'd0, 32'hE3, 2'b00);
        v(1, 2'b10, 32'h0,  32'hF1, 2'b00, 1, 2'b00, 2'b10, 0, 3'd4, 32'hF0, 2'b00);
        v(0, 2'b11, 32'hC6, 32'hC7, 2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'h0,  2'b00);
        v(0, 2'b11, 32'hC6, 32'hC7, 2'b00, 1, 2'b01, 2'b01, 1, 3'd0, 32'h0,  2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b01, 0, 3'd0, 32'hC6, 2'b00);
        v(0, 2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b00, 2'b00, 1, 3'd0, 32'hC6, 2'b00);

        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.ptr_clr  = '0;
        bus.mem_wr_rdy = 1'b1;
        tick();
        tick();

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            bus.req        = vecs[i].req;
            bus.req_data   = {vecs[i].d1, vecs[i].d0};
            bus.ptr_clr    = vecs[i].clr;
            bus.mem_wr_rdy = vecs[i].rdy;
            #2;
            chk($sformatf("row%0d ack", i),  32'(bus.ack),         32'(vecs[i].ack));
            chk($sformatf("row%0d gnt", i),  32'(bus.gnt),         32'(vecs[i].gnt));
            chk($sformatf("row%0d en_n", i), 32'(bus.mem_wr_en_n), 32'(vecs[i].en_n));
            chk($sformatf("row%0d addr", i), 32'(bus.mem_wr_addr), 32'(vecs[i].addr));
            chk($sformatf("row%0d data", i), bus.mem_wr_data,      vecs[i].data);
            chk($sformatf("row%0d fd", i),   32'(bus.frame_done),  32'(vecs[i].fd));
            tick();
        end

        // Sustained contention from rr_ptr=1: owners 1,0,1, four beats each, one dead cycle between.
        reset          = 1'b0;
        bus.req        = 2'b11;
        bus.req_data   = {32'h5555_0001, 32'h5555_0000};
        bus.ptr_clr    = '0;
        bus.mem_wr_rdy = 1'b1;
        exp_gnt        = 2'b10;
        for (int b = 0; b < 3; b++) begin
            wait_cnt = 0;
            while (bus.gnt == 2'b00 && wait_cnt < 10) begin
                tick();
                wait_cnt++;
            end
            chk($sformatf("burst%0d idle_gap", b), 32'(wait_cnt), 32'd1);
            chk($sformatf("burst%0d owner", b),    32'(bus.gnt),  32'(exp_gnt));
            beats = 0;
            while (bus.gnt != 2'b00 && beats < 20) begin
                if (bus.ack == bus.gnt) beats++;
                tick();
            end
            chk($sformatf("burst%0d beats", b), 32'(beats), 32'd4);
            exp_gnt = ~exp_gnt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buf_wr_arb.md
Name: frame_buf_wr_arb

Overview:
- Write-side arbiter that shares one frame-buffer data memory write port between NUM_REQ producers (e.g. capture sources).
- Grants bursts round-robin and gives each requester a private address region.
- Drives the memory's active-low write enable, address and data, and honours the memory's write-ready.
- Reports per-requester frame completion when a region pointer wraps.

Parameters:
- DATA_WIDTH, 32, width of one memory word.
- ADDR_WIDTH, 3, memory address width; MEM_DEPTH = 1 << ADDR_WIDTH.
- NUM_REQ, 2, number of requesters, ≥ 2.
- BURST_LEN, 4, maximum beats per grant, ≥ 1.
- REGION_DEPTH, MEM_DEPTH/NUM_REQ, words per requester region; NUM_REQ*REGION_DEPTH ≤ MEM_DEPTH.

Ports:
- wr_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  requester i holds a valid word on its req_data slice.
- req_data  in  NUM_REQ*DATA_WIDTH  slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- ptr_clr  in  NUM_REQ  clear requester i's region pointer to 0.
- gnt  out  NUM_REQ  one-hot current owner, registered.
- ack  out  NUM_REQ  combinational; word on slice i accepted this cycle.
- mem_wr_en_n  out  1  memory write enable, active-low, registered.
- mem_wr_addr  out  ADDR_WIDTH  registered.
- mem_wr_data  out  DATA_WIDTH  registered.
- mem_wr_rdy  in  1  memory can accept a write this cycle.
- frame_done  out  NUM_REQ  one-cycle pulse when region i pointer wraps, registered.

Behaviour:
- Reset values: state IDLE; gnt=0; mem_wr_en_n=1; mem_wr_addr=0; mem_wr_data=0; frame_done=0; all region pointers=0; beat_cnt=0; rr_ptr=0 (requester 0 has first priority).
- ack is forced to 0 while reset=1.
- States: IDLE, BURST.
- IDLE, any req bit set:
  - Pick the first set bit scanning circularly from rr_ptr.
  - Set gnt to that one-hot (owner g), beat_cnt<=0, go to BURST.
- IDLE, no req: stay in IDLE, gnt=0.
- Grant latency: req rises in cycle N while IDLE → gnt valid in N+1; first ack possible in N+1.
- BURST, beat condition: ack[g] = (state==BURST) & gnt[g] & req[g] & mem_wr_rdy. All other ack bits are 0.
- On a beat in cycle N, at the next edge:
  - mem_wr_en_n<=0.
  - mem_wr_addr <= g*REGION_DEPTH + ptr[g], truncated to ADDR_WIDTH.
  - mem_wr_data <= slice g.
  - ptr[g] increments and beat_cnt increments.
  - The written word appears on the memory port in N+1.
- Any cycle without a beat: mem_wr_en_n<=1. Address and data hold their last values.
- Region wrap: on a beat with ptr[g]==REGION_DEPTH-1, ptr[g]<=0 and frame_done[g] pulses high for exactly one cycle (N+1).
- Burst end: on a beat with beat_cnt==BURST_LEN-1, or in any BURST cycle with req[g]==0:
  - Next state IDLE, gnt<=0, rr_ptr <= (g+1) mod NUM_REQ.
- Burst end is not triggered by mem_wr_rdy=0. A stall holds the burst with beat_cnt unchanged.
- One dead IDLE cycle always separates consecutive bursts.
- ptr_clr[i]: ptr[i]<=0 at the next edge, with priority over increment.
  - If coincident with a beat for i, the word is written at the old pointer, then ptr[i]=0.
  - No frame_done pulse is generated by ptr_clr.
- Pointers are not reset by grants or burst ends; each region continues where it left off.
- Reset mid-burst: at the next edge all state returns to reset values. Pending words are not written. ack drops in the reset cycle itself.

Test Plan:
- Single requester: req[0]=1 for 4 words A0..A3, mem_wr_rdy=1 → gnt=01 one cycle later; ack[0] high 4 cycles; mem addrs 0,1,2,3 with mem_wr_en_n=0 for 4 cycles; frame_done[0] pulses after A3; gnt=00 next.
- Contention: req=11 held continuously → bursts alternate 0,1,0,1 with one IDLE cycle between each; requester 1 writes addrs 4..7; rr_ptr wrap verified.
- Stall: in a burst, mem_wr_rdy=0 for 3 cycles after beat 2 → ack=0 and mem_wr_en_n=1 for 3 cycles; burst still ends after exactly 4 beats, at addresses unchanged in sequence.
- Early release: req[1] drops after 2 beats → requester 1 writes addrs 4,5 then IDLE; next requester 1 burst resumes at addr 6; wrap to 4 raises frame_done[1] after addr 7.
- ptr_clr on a beat: ptr_clr[0]=1 coincident with the beat at addr 2 → word written at 2; next beat writes addr 0; no frame_done[0].
- Reset mid-burst: assert reset after beat 1 → ack=0 in that cycle; next cycle gnt=0, mem_wr_en_n=1, addr=0; new request restarts at addr 0 with requester 0 priority.
